// File: rtl/bus_slave_regs.sv
// bus_slave_regs: a 16-word register slave behind a select/ack handshake.
// Registers 0..14 are read/write. Register 15 is a read-only count of completed
// transfers. Each transfer is captured in IDLE, then optionally delayed in WAIT,
// then acknowledged for one cycle in ACK. The FSM parks in HOLD until the master
// releases select.
module bus_slave_regs #(
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [31:0] RESET_VALUE = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        select_i,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        ack_o
);

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned IDX_W    = 4;
    localparam int unsigned CNT_W    = 4;
    localparam int unsigned NUM_REGS = 16;

    localparam logic [IDX_W-1:0] CNT_IDX   = IDX_W'(NUM_REGS - 1);
    localparam logic [CNT_W-1:0] WAIT_INIT = (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : CNT_W'(0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_wait_cnt;
    logic [IDX_W-1:0]    r_addr;
    logic                r_we;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_regs [NUM_REGS-1];
    logic [DATA_W-1:0]   r_txn_cnt;
    logic [DATA_W-1:0]   r_data_o;
    logic                r_ack;

    logic [IDX_W-1:0]    w_rd_addr;
    logic [DATA_W-1:0]   w_rd_data;
    logic                w_unused_addr;

    // Only the word index is decoded; the other address bits are ignored.
    assign w_unused_addr = ^{addr_i[31:6], addr_i[1:0]};

    // Read mux. With no wait states ACK is entered on the capture edge, so the
    // live address is used in IDLE and the latched address everywhere else.
    always_comb begin
        w_rd_addr = (r_state == IDLE) ? addr_i[5:2] : r_addr;
        w_rd_data = r_txn_cnt;
        if (w_rd_addr != CNT_IDX) begin
            w_rd_data = r_regs[w_rd_addr];
        end
    end

    // Handshake FSM, register file and transfer counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_wait_cnt <= '0;
            r_addr     <= '0;
            r_we       <= 1'b0;
            r_wdata    <= '0;
            r_txn_cnt  <= '0;
            r_data_o   <= '0;
            r_ack      <= 1'b0;
            for (int k = 0; k < int'(NUM_REGS - 1); k++) begin
                r_regs[k] <= RESET_VALUE;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (select_i) begin
                        r_addr  <= addr_i[5:2];
                        r_we    <= we_i;
                        r_wdata <= data_i;
                        if (WAIT_STATES > 0) begin
                            r_state    <= WAIT;
                            r_wait_cnt <= WAIT_INIT;
                        end else begin
                            r_state  <= ACK;
                            r_ack    <= 1'b1;
                            r_data_o <= we_i ? '0 : w_rd_data;
                        end
                    end
                end
                WAIT: begin
                    if (!select_i) begin
                        r_state <= IDLE;
                    end else if (r_wait_cnt == '0) begin
                        r_state  <= ACK;
                        r_ack    <= 1'b1;
                        r_data_o <= r_we ? '0 : w_rd_data;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - CNT_W'(1);
                    end
                end
                ACK: begin
                    r_ack     <= 1'b0;
                    r_data_o  <= '0;
                    r_txn_cnt <= r_txn_cnt + DATA_W'(1);
                    if (r_we && (r_addr != CNT_IDX)) begin
                        r_regs[r_addr] <= r_wdata;
                    end
                    r_state <= select_i ? HOLD : IDLE;
                end
                HOLD: begin
                    if (!select_i) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign data_o = r_data_o;
    assign ack_o  = r_ack;

endmodule

// File: tb/tb_bus_slave_regs.sv
// Bench for bus_slave_regs: three instances (0, 1 and 3 wait states) driven
// through a transfer task. Expected read data and latency are pushed to a
// scoreboard queue when a transfer is issued. They are popped and compared
// when ack is seen.
module tb_bus_slave_regs;

    localparam int unsigned N_DUT = 3;
    localparam logic [31:0] RV_WS1 = 32'h1357_9BDF;
    localparam logic [31:0] RV_WS0 = 32'h0000_0000;
    localparam logic [31:0] RV_WS3 = 32'hA5A5_5A5A;

    typedef struct {
        logic [31:0] data;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n [N_DUT];
    logic        sel   [N_DUT];
    logic        we    [N_DUT];
    logic [31:0] addr  [N_DUT];
    logic [31:0] din   [N_DUT];
    logic [31:0] dout  [N_DUT];
    logic        ack   [N_DUT];

    logic [31:0] m_regs [N_DUT][16];
    logic [31:0] m_cnt  [N_DUT];
    exp_t        sb_q [$];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bus_slave_regs #(.WAIT_STATES(1), .RESET_VALUE(RV_WS1)) u_ws1 (
        .clk(clk), .rst(rst_n[0]), .select_i(sel[0]), .addr_i(addr[0]),
        .we_i(we[0]), .data_i(din[0]), .data_o(dout[0]), .ack_o(ack[0]));

    bus_slave_regs #(.WAIT_STATES(0), .RESET_VALUE(RV_WS0)) u_ws0 (
        .clk(clk), .rst(rst_n[1]), .select_i(sel[1]), .addr_i(addr[1]),
        .we_i(we[1]), .data_i(din[1]), .data_o(dout[1]), .ack_o(ack[1]));

    bus_slave_regs #(.WAIT_STATES(3), .RESET_VALUE(RV_WS3)) u_ws3 (
        .clk(clk), .rst(rst_n[2]), .select_i(sel[2]), .addr_i(addr[2]),
        .we_i(we[2]), .data_i(din[2]), .data_o(dout[2]), .ack_o(ack[2]));

    function automatic int ws_of(input int i);
        case (i)
            0:       return 1;
            1:       return 0;
            default: return 3;
        endcase
    endfunction

    function automatic logic [31:0] rv_of(input int i);
        case (i)
            0:       return RV_WS1;
            1:       return RV_WS0;
            default: return RV_WS3;
        endcase
    endfunction

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic model_reset(input int i);
        for (int r = 0; r < 15; r++) m_regs[i][r] = rv_of(i);
        m_cnt[i] = 32'h0;
    endtask

    // Complete one transfer. hold = cycles select stays high after ack (0 drops it in the ack cycle).
    task automatic xfer(input int i, input logic w, input logic [31:0] a, input logic [31:0] d, input int hold);
        exp_t e;
        exp_t got;
        int cyc;
        logic [3:0] ri;
        ri = a[5:2];
        e.lat  = ws_of(i) + 1;
        e.data = w ? 32'h0 : ((ri == 4'd15) ? m_cnt[i] : m_regs[i][ri]);
        sb_q.push_back(e);
        @(negedge clk);
        sel[i] = 1'b1; we[i] = w; addr[i] = a; din[i] = d;
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (ack[i] === 1'b1 || cyc >= 40) break;
            check_val("pre_ack_data", dout[i], 32'h0);
            addr[i] = $urandom; din[i] = $urandom; we[i] = 1'($urandom_range(0, 1));
        end
        got = sb_q.pop_front();
        check_val("ack_latency", 32'(cyc), 32'(got.lat));
        if (ack[i] === 1'b1) begin
            check_val("ack_data", dout[i], got.data);
            if (w && ri != 4'd15) m_regs[i][ri] = d;
            m_cnt[i] = m_cnt[i] + 32'h1;
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check_val("hold_ack", 32'(ack[i]), 32'h0);
            check_val("hold_data", dout[i], 32'h0);
            addr[i] = $urandom; we[i] = 1'($urandom_range(0, 1));
        end
        sel[i] = 1'b0;
        @(negedge clk);
        check_val("ack_single", 32'(ack[i]), 32'h0);
        check_val("post_data", dout[i], 32'h0);
    endtask

    initial begin
        for (int i = 0; i < int'(N_DUT); i++) begin
            rst_n[i] = 1'b0; sel[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; din[i] = '0;
            model_reset(i);
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < int'(N_DUT); i++) begin
            check_val("rst_ack", 32'(ack[i]), 32'h0);
            check_val("rst_data", dout[i], 32'h0);
            rst_n[i] = 1'b1;
        end

        // Write then read back, 1 wait state
        xfer(0, 1'b1, 32'h08, 32'hDEAD_BEEF, 0);
        xfer(0, 1'b0, 32'h08, 32'h0, 0);
        xfer(0, 1'b0, 32'h0C, 32'h0, 0);
        // Long hold after ack: one pulse, one increment
        xfer(0, 1'b0, 32'h08, 32'h0, 10);
        xfer(0, 1'b0, 32'h3C, 32'h0, 0);

        // Counter reads with zero wait states
        xfer(1, 1'b0, 32'h3C, 32'h0, 0);
        xfer(1, 1'b0, 32'h3C, 32'h0, 0);
        // Counter is read-only
        xfer(1, 1'b1, 32'h3C, 32'h0000_0055, 2);
        xfer(1, 1'b0, 32'h3C, 32'h0, 0);
        xfer(1, 1'b1, 32'h20, 32'h0BAD_F00D, 0);
        xfer(1, 1'b0, 32'h20, 32'h0, 0);

        // Abort during WAIT (3 wait states)
        @(negedge clk);
        sel[2] = 1'b1; we[2] = 1'b1; addr[2] = 32'h00; din[2] = 32'h1234_5678;
        repeat (2) begin
            @(negedge clk);
            check_val("abort_wait_ack", 32'(ack[2]), 32'h0);
        end
        sel[2] = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check_val("abort_no_ack", 32'(ack[2]), 32'h0);
        end
        xfer(2, 1'b0, 32'h00, 32'h0, 0);
        xfer(2, 1'b0, 32'h3C, 32'h0, 0);

        // Write/read sweep on the 3 wait state instance
        for (int k = 0; k < 6; k++) xfer(2, 1'b1, 32'(k * 4), $urandom, k % 2);
        for (int k = 0; k < 7; k++) xfer(2, 1'b0, 32'(k * 4), 32'h0, 0);

        // Reset during WAIT of a write to 0x04
        @(negedge clk);
        sel[2] = 1'b1; we[2] = 1'b1; addr[2] = 32'h04; din[2] = 32'hCAFE_F00D;
        @(negedge clk);
        #1 rst_n[2] = 1'b0;
        #1;
        check_val("rst_wait_ack", 32'(ack[2]), 32'h0);
        check_val("rst_wait_data", dout[2], 32'h0);
        @(negedge clk);
        sel[2] = 1'b0; rst_n[2] = 1'b1;
        model_reset(2);
        xfer(2, 1'b0, 32'h04, 32'h0, 0);

        // Reset during the ACK cycle of a write drops ack and loses the write
        @(negedge clk);
        sel[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h10; din[0] = 32'h7777_8888;
        repeat (2) @(negedge clk);
        check_val("pre_rst_ack", 32'(ack[0]), 32'h1);
        rst_n[0] = 1'b0;
        #1;
        check_val("rst_ack_drop", 32'(ack[0]), 32'h0);
        check_val("rst_ack_data", dout[0], 32'h0);
        @(negedge clk);
        sel[0] = 1'b0; rst_n[0] = 1'b1;
        model_reset(0);
        xfer(0, 1'b0, 32'h10, 32'h0, 0);
        xfer(0, 1'b0, 32'h3C, 32'h0, 0);

        // Counter wrap
        @(negedge clk);
        force u_ws0.r_txn_cnt = 32'hFFFF_FFFF;
        @(negedge clk);
        release u_ws0.r_txn_cnt;
        m_cnt[1] = 32'hFFFF_FFFF;
        xfer(1, 1'b0, 32'h3C, 32'h0, 0);
        xfer(1, 1'b0, 32'h3C, 32'h0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
